// File: rtl/piso_tx_pkg.sv
// Shared types and default sizing for the PISO serial transmit path.
package piso_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  localparam int unsigned DefWidth      = 8;
  localparam int unsigned DefClksPerBit = 4;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register: load beats shift, shifts left with zero fill.
module piso_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/piso_tx_ctrl.sv
// Frame sequencer: start bit, MSB-first data, optional parity, stop bit, each bit
// held CLKS_PER_BIT clocks. Outputs are decoded from registered state only.
module piso_tx_ctrl
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = DefWidth,
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(WIDTH) + 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WIDTH - 1);

  tx_state_t        state_q;
  logic [BaudW-1:0] baud_q;
  logic [BitW-1:0]  bit_q;
  logic             parity_q;
  logic [WIDTH-1:0] shreg_q;
  logic             baud_end;
  logic             load;
  logic             shift;
  logic             unused_shreg;

  assign baud_end = (baud_q == BaudLast);
  assign load     = (state_q == StIdle) && in_valid;
  assign shift    = (state_q == StData) && baud_end;

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .d    (in_data),
    .q    (shreg_q)
  );

  // Only the MSB reaches the line; the rest of the register just feeds it.
  assign unused_shreg = ^shreg_q[WIDTH-2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      // The baud counter clears at every bit boundary, which is also every state change.
      if (state_q == StIdle || baud_end) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (in_valid) begin
            bit_q    <= '0;
            parity_q <= (^in_data) ^ PARITY_ODD;
            state_q  <= StStart;
          end
        end
        StStart: begin
          if (baud_end) state_q <= StData;
        end
        StData: begin
          if (baud_end) begin
            bit_q <= bit_q + 1'b1;
            if (bit_q == BitLast) state_q <= PARITY_EN ? StParity : StStop;
          end
        end
        StParity: begin
          if (baud_end) state_q <= StStop;
        end
        StStop: begin
          if (baud_end) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StStop) && baud_end;

  always_comb begin
    sdo = 1'b1;
    case (state_q)
      StStart:  sdo = 1'b0;
      StData:   sdo = shreg_q[WIDTH-1];
      StParity: sdo = parity_q;
      default:  sdo = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Randomized bench for piso_tx_ctrl: three configurations checked against a frame model.
module tb_piso_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data_a, data_b, data_c;
  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       sdo_a, sdo_b, sdo_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  // Configurations: 0 = defaults, 1 = odd parity, 2 = one clock per bit without parity.
  int cfg_cpb[3] = '{4, 4, 1};
  int cfg_pe[3]  = '{1, 1, 0};
  int cfg_odd[3] = '{0, 1, 0};

  piso_tx_ctrl #(
    .WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .in_data(data_a), .in_valid(valid_a), .in_ready(ready_a),
    .sdo(sdo_a), .busy(busy_a), .done(done_a)
  );

  piso_tx_ctrl #(
    .WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .in_data(data_b), .in_valid(valid_b), .in_ready(ready_b),
    .sdo(sdo_b), .busy(busy_b), .done(done_b)
  );

  piso_tx_ctrl #(
    .WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) u_dut_c (
    .clk(clk), .rst(rst), .in_data(data_c), .in_valid(valid_c), .in_ready(ready_c),
    .sdo(sdo_c), .busy(busy_c), .done(done_c)
  );

  logic obs_sdo, obs_ready, obs_busy, obs_done;
  always_comb begin
    obs_sdo = sdo_a; obs_ready = ready_a; obs_busy = busy_a; obs_done = done_a;
    case (sel)
      1: begin obs_sdo = sdo_b; obs_ready = ready_b; obs_busy = busy_b; obs_done = done_b; end
      2: begin obs_sdo = sdo_c; obs_ready = ready_c; obs_busy = busy_c; obs_done = done_c; end
      default: ;
    endcase
  end

  function automatic int frame_len(input int s);
    return (2 + 8 + cfg_pe[s]) * cfg_cpb[s];
  endfunction

  // Line level c clocks after the handshake edge, straight from the frame definition.
  function automatic logic exp_sdo(input int s, input logic [7:0] w, input int c);
    int   b;
    logic p;
    b = c / cfg_cpb[s];
    if (b == 0) return 1'b0;
    if (b <= 8) return w[8-b];
    if (cfg_pe[s] == 1 && b == 9) begin
      p = ^w;
      if (cfg_odd[s] == 1) p = ~p;
      return p;
    end
    return 1'b1;
  endfunction

  task automatic drive(input int s, input logic v, input logic [7:0] w);
    case (s)
      0: begin valid_a = v; data_a = w; end
      1: begin valid_b = v; data_b = w; end
      default: begin valid_c = v; data_c = w; end
    endcase
  endtask

  // Waits (bounded) for IDLE, then performs one handshake; ends 1 time unit after that edge.
  task automatic send(input int s, input logic [7:0] w, input bit hold);
    int n;
    sel = s;
    #1;
    n = 0;
    while (!obs_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!obs_ready) begin
      errors++;
      $display("FAIL idle_wait cfg=%0d: in_ready=%b after %0d clocks, required 1", s, obs_ready, n);
    end
    drive(s, 1'b1, w);
    @(posedge clk);
    #1;
    if (!hold) drive(s, 1'b0, 8'h00);
  endtask

  // Checks every clock of a frame whose handshake was the previous edge, then the idle clock.
  task automatic frame_check(input int s, input logic [7:0] w);
    int         len;
    logic [3:0] got, exp;
    len = frame_len(s);
    for (int c = 0; c < len; c++) begin
      got = {obs_sdo, obs_done, obs_busy, obs_ready};
      exp = {exp_sdo(s, w, c), (c == len - 1), 1'b1, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL frame cfg=%0d word=%h cycle=%0d {sdo,done,busy,ready}: got %b required %b",
                 s, w, c, got, exp);
      end
      if (c < len - 1) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    got = {obs_ready, obs_busy, obs_sdo, obs_done};
    checks++;
    if (got !== 4'b1010) begin
      errors++;
      $display("FAIL post_frame cfg=%0d word=%h {ready,busy,sdo,done}: got %b required 1010",
               s, w, got);
    end
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst = 1'b1;
    drive(0, 1'b1, 8'hA5);
    drive(1, 1'b1, 8'h5A);
    drive(2, 1'b1, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
        sel = s;
        #1;
        got = {obs_ready, obs_busy, obs_sdo, obs_done};
        checks++;
        if (got !== 4'b1010) begin
          errors++;
          $display("FAIL reset cfg=%0d clk=%0d {ready,busy,sdo,done}: got %b required 1010",
                   s, i, got);
        end
      end
    end
    rst = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      got = {obs_ready, obs_busy, obs_sdo, obs_done};
      checks++;
      if (got !== 4'b1010) begin
        errors++;
        $display("FAIL reset_release cfg=%0d {ready,busy,sdo,done}: got %b required 1010", s, got);
      end
    end
  endtask

  task automatic test_frame();
    logic [7:0] w;
    send(0, 8'hA5, 1'b0);
    frame_check(0, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      w = 8'($urandom_range(255, 0));
      send(0, w, 1'b0);
      frame_check(0, w);
    end
  endtask

  task automatic test_odd_parity();
    logic [7:0] w;
    send(1, 8'h00, 1'b0);
    frame_check(1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      w = 8'($urandom_range(255, 0));
      send(1, w, 1'b0);
      frame_check(1, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1, w2;
    send(0, 8'h3C, 1'b1);
    drive(0, 1'b1, 8'hC3);
    frame_check(0, 8'h3C);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 8'h00);
    frame_check(0, 8'hC3);
    w1 = 8'($urandom_range(255, 0));
    w2 = 8'($urandom_range(255, 0));
    send(0, w1, 1'b1);
    drive(0, 1'b1, w2);
    frame_check(0, w1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 8'h00);
    frame_check(0, w2);
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    logic [3:0] got;
    int         done_seen;
    w = 8'($urandom_range(255, 0));
    send(0, w, 1'b0);
    // Clock 17 is inside the fourth data bit.
    repeat (17) @(posedge clk);
    #1;
    checks++;
    if (obs_sdo !== exp_sdo(0, w, 17)) begin
      errors++;
      $display("FAIL mid_frame_bit word=%h: sdo=%b required %b", w, obs_sdo, exp_sdo(0, w, 17));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    got = {obs_ready, obs_busy, obs_sdo, obs_done};
    checks++;
    if (got !== 4'b1010) begin
      errors++;
      $display("FAIL abort {ready,busy,sdo,done}: got %b required 1010", got);
    end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (obs_done || obs_busy || !obs_sdo) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d non-idle clocks after abort, required 0", done_seen);
    end
    w = 8'($urandom_range(255, 0));
    send(0, w, 1'b0);
    frame_check(0, w);
  endtask

  task automatic test_min_baud();
    logic [7:0] w;
    send(2, 8'h81, 1'b0);
    frame_check(2, 8'h81);
    for (int i = 0; i < 3; i++) begin
      w = 8'($urandom_range(255, 0));
      send(2, w, 1'b0);
      frame_check(2, w);
    end
    send(2, 8'h5A, 1'b1);
    drive(2, 1'b1, 8'hE7);
    frame_check(2, 8'h5A);
    @(posedge clk);
    #1;
    drive(2, 1'b0, 8'h00);
    frame_check(2, 8'hE7);
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'h00);
    test_reset();
    test_frame();
    test_odd_parity();
    test_back_to_back();
    test_reset_mid();
    test_min_baud();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/piso_tx_ctrl.md
# piso_tx_ctrl

Frame sequencer for the 8-bit parallel-in/serial-out shift path. It accepts a parallel word over a valid/ready handshake and loads it into an internal PISO shift register. It then drives a framed serial line: start bit, data bits MSB first, optional parity bit, stop bit, with each bit held for a programmable number of clocks. It sits between a parallel producer and the serial pin. It is the only block that issues load/shift commands to the shift register.

## Interface
- `WIDTH`, default 8: data word width; must be ≥ 2.
- `CLKS_PER_BIT`, default 4: clocks per serial bit; must be ≥ 1.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  WIDTH  parallel word; sampled only on handshake.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  controller can accept a word; high only in IDLE.
- `sdo`  out  1  serial data out; idle level 1.
- `busy`  out  1  frame in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse in the final clock of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset values:
  - state IDLE.
  - `sdo`=1, `in_ready`=1, `busy`=0, `done`=0.
  - Shift register, baud counter and bit counter all 0.
- IDLE:
  - `sdo`=1, `in_ready`=1.
  - On `in_valid`&&`in_ready`, load `in_data` into the shift register (load mode).
  - At the same edge, latch parity and go to START. Parity = XOR of all bits, inverted when `PARITY_ODD`=1.
- START: `sdo`=0 for CLKS_PER_BIT clocks, then go to DATA.
- DATA:
  - `sdo` = shift register MSB.
  - When the baud counter reaches CLKS_PER_BIT-1, shift left with 0 fill and increment the bit counter.
  - After WIDTH bits, go to PARITY if `PARITY_EN`=1, else to STOP.
- PARITY: `sdo` = latched parity for CLKS_PER_BIT clocks, then go to STOP.
- STOP:
  - `sdo`=1 for CLKS_PER_BIT clocks.
  - `done`=1 in the last of those clocks, then go to IDLE.
- Counters:
  - Baud counter width is max(1, $clog2(CLKS_PER_BIT)). It resets to 0 on every state change and wraps at CLKS_PER_BIT-1.
  - Bit counter width is $clog2(WIDTH)+1. It clears on load.
- `in_data` and `in_valid` are ignored outside IDLE. A word held valid across a frame is accepted only in the next IDLE cycle.
- Reset during any state:
  - Next edge gives IDLE and `sdo`=1.
  - No `done` pulse; the partial frame is abandoned.
  - A handshake in the same cycle as `rst` is discarded.

## Timing
- `sdo`, `in_ready`, `busy` and `done` are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- Handshake at edge E:
  - The start bit appears on `sdo` from E to E + CLKS_PER_BIT.
  - The first data bit (bit WIDTH-1) follows immediately after.
- Frame length is (2 + WIDTH + PARITY_EN) × CLKS_PER_BIT clocks from E.
- `done` is high in the final frame clock. `in_ready` rises the following clock.
- Back-to-back words: a minimum of one IDLE clock (`sdo`=1) separates frames.
- Throughput is one word per (2 + WIDTH + PARITY_EN) × CLKS_PER_BIT + 1 clocks.

## Structure
- Package `piso_tx_pkg` holds:
  - `tx_state_t`, the enum of the five states.
  - Default `WIDTH`/`CLKS_PER_BIT` constants.
- Sub-module `piso_shift_reg`:
  - Parameterized WIDTH; ports `load`, `shift`, `d`, `q`.
  - Synchronous active-high reset.
  - Load has priority over shift.
  - Left shift with LSB fill 0.
- `piso_tx_ctrl` contains the FSM, the baud and bit counters, the parity latch and the output decode.

## Test plan
- Reset: assert `rst` 2 clocks with `in_valid`=1 → `sdo`=1, `in_ready`=1, `busy`=0, `done`=0, no frame starts.
- Defaults, `in_data`=8'hA5 accepted at cycle 0:
  - `sdo` sequence is 0,1,0,1,0,0,1,0,1,0,1, each bit 4 clocks.
  - Parity is even, and A5 has 4 ones → parity bit 0.
  - `done` is high at cycle 43; `in_ready` is high at cycle 44.
- `PARITY_ODD`=1, `in_data`=8'h00 → parity bit 1; frame is 44 clocks.
- `in_valid` held high with 8'h3C then 8'hC3:
  - Second word is accepted in the single IDLE clock after `done`.
  - Exactly one `sdo`=1 idle clock separates the frames.
  - 8'hC3 is not sampled during the first frame.
- `rst` pulsed during DATA bit 3 → next clock gives IDLE, `sdo`=1, no `done`; a fresh word then produces a full, correct frame.
- `CLKS_PER_BIT`=1, `PARITY_EN`=0, `in_data`=8'h81 → `sdo` = 0,1,0,0,0,0,0,0,1,1 over 10 clocks, with `done` on the 10th.
